eva_ahb_slv_mem: RTL and testbench

//  AHB-Lite slave: word-addressed register memory with programmable wait states
//  and two-cycle ERROR response. Sits on the EVA AHB bus as the target of the
//  EVA bus-function master, giving the C-side model a real responder for

---
 rtl/eva_ahb_slv_mem.sv | 128 ++++++++++++
 tb/tb_eva_ahb_slv_mem.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eva_ahb_slv_mem.sv
// AHB-Lite slave: word-addressed register memory with programmable wait states
// and a two-cycle ERROR response.
module eva_ahb_slv_mem #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned WAIT_CNT  = 0
) (
  input  logic        hclk,
  input  logic        hrest_n,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [31:0] haddr,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam logic [32:0] WIN_BYTES = 33'(4 * DEPTH);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CNT > 0) ? 4'(WAIT_CNT - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       mem [DEPTH];
  logic [3:0]        wcnt;
  logic              lat_write;
  logic [2:0]        lat_size;
  logic [1:0]        lat_lo;
  logic [IDX_W-1:0]  lat_idx;
  logic [32:0]       offset;
  logic              can_accept;
  logic              accept;
  logic              req_err;
  logic [3:0]        lanes;

  // 33-bit offset: bit 32 flags an address below the window base
  assign offset     = {1'b0, haddr} - {1'b0, ADDR_BASE};
  assign can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign accept     = can_accept && hsel && hready && (htrans == 2'b10 || htrans == 2'b11);

  always_comb begin
    req_err = offset[32] || (offset >= WIN_BYTES) || (hsize > 3'd2) ||
              (hsize == 3'd1 && haddr[0]) ||
              (hsize == 3'd2 && haddr[1:0] != 2'b00);
  end

  always_ff @(posedge hclk or negedge hrest_n) begin
    if (!hrest_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hreadyout = 1'b1;
    hresp     = 2'b00;
    hrdata    = '0;
    case (state)
      ST_WAIT: begin
        hreadyout = 1'b0;
        if (wcnt == 4'd0) state_nxt = ST_DATA;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 2'b01;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: hresp = 2'b01;
      ST_DATA: if (!lat_write) hrdata = mem[lat_idx];
      default: ;
    endcase
    // Completing states overlap the next address phase (pipelined accept)
    if (can_accept) begin
      if (!accept)            state_nxt = ST_IDLE;
      else if (req_err)       state_nxt = ST_ERR1;
      else if (WAIT_CNT == 0) state_nxt = ST_DATA;
      else                    state_nxt = ST_WAIT;
    end
  end

  always_ff @(posedge hclk or negedge hrest_n) begin
    if (!hrest_n) begin
      lat_write <= 1'b0;
      lat_size  <= '0;
      lat_lo    <= '0;
      lat_idx   <= '0;
      wcnt      <= '0;
    end else if (accept) begin
      lat_write <= hwrite;
      lat_size  <= hsize;
      lat_lo    <= haddr[1:0];
      lat_idx   <= offset[IDX_W+1:2];
      wcnt      <= WAIT_LOAD;
    end else if (state == ST_WAIT && wcnt != 4'd0) begin
      wcnt <= wcnt - 4'd1;
    end
  end

  always_comb begin
    lanes = '0;
    case (lat_size)
      3'd0:    lanes[lat_lo] = 1'b1;
      3'd1:    lanes = lat_lo[1] ? 4'b1100 : 4'b0011;
      3'd2:    lanes = 4'b1111;
      default: lanes = '0;
    endcase
  end

  always_ff @(posedge hclk or negedge hrest_n) begin
    if (!hrest_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == ST_DATA && lat_write) begin
      for (int unsigned b = 0; b < 4; b++)
        if (lanes[b]) mem[lat_idx][8*b +: 8] <= hwdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_eva_ahb_slv_mem.sv
// Bench for eva_ahb_slv_mem: a zero-wait and a three-wait instance share one
// bus; a pipelined driver records per-transfer responses for a scoreboard.
module tb_eva_ahb_slv_mem;

  logic        hclk = 1'b0;
  logic        hrest_n = 1'b0;
  logic        hsel = 1'b0;
  logic        sel3 = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [31:0] haddr = '0;
  logic [2:0]  hsize = 3'd0;
  logic [31:0] hwdata = '0;
  logic        hready_bus;
  logic [1:0]  hresp_bus;
  logic [31:0] hrdata_bus;
  logic        rdy0, rdy3;
  logic [1:0]  resp0, resp3;
  logic [31:0] rd0, rd3;

  always #5 hclk = ~hclk;

  eva_ahb_slv_mem #(.ADDR_BASE(32'h0), .DEPTH(256), .WAIT_CNT(0)) u_dut0 (
    .hclk(hclk), .hrest_n(hrest_n), .hsel(hsel & ~sel3), .htrans(htrans),
    .hwrite(hwrite), .haddr(haddr), .hsize(hsize), .hwdata(hwdata),
    .hready(hready_bus), .hreadyout(rdy0), .hresp(resp0), .hrdata(rd0));

  eva_ahb_slv_mem #(.ADDR_BASE(32'h0), .DEPTH(16), .WAIT_CNT(3)) u_dut3 (
    .hclk(hclk), .hrest_n(hrest_n), .hsel(hsel & sel3), .htrans(htrans),
    .hwrite(hwrite), .haddr(haddr), .hsize(hsize), .hwdata(hwdata),
    .hready(hready_bus), .hreadyout(rdy3), .hresp(resp3), .hrdata(rd3));

  assign hready_bus = sel3 ? rdy3  : rdy0;
  assign hresp_bus  = sel3 ? resp3 : resp0;
  assign hrdata_bus = sel3 ? rd3   : rd0;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [3:0]  waits;
    logic [1:0]  wresp;
  } obs_t;

  cmd_t cmd_q[$];
  obs_t exp_q[$];
  obs_t obs_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t okay(input logic [31:0] d, input logic [3:0] w);
    okay = '{rdata: d, resp: 2'b00, waits: w, wresp: 2'b00};
  endfunction

  function automatic obs_t err_rsp();
    err_rsp = '{rdata: 32'h0, resp: 2'b01, waits: 4'd1, wresp: 2'b01};
  endfunction

  task automatic add(input logic sel, input logic [1:0] trans, input logic write,
                     input logic [31:0] addr, input logic [2:0] size,
                     input logic [31:0] wdata, input obs_t e);
    cmd_t c;
    c.sel = sel; c.trans = trans; c.write = write;
    c.addr = addr; c.size = size; c.wdata = wdata;
    cmd_q.push_back(c);
    exp_q.push_back(e);
  endtask

  // Drives queued address phases back-to-back; every command (idle ones too)
  // yields one observation covering its data phase.
  task automatic run_cmds();
    int   i = 0;
    int   guard = 0;
    bit   have_dp = 0;
    bit   rdy;
    cmd_t dp;
    obs_t ob;
    while ((i < cmd_q.size() || have_dp) && guard < 200) begin
      guard++;
      if (i < cmd_q.size()) begin
        hsel = cmd_q[i].sel; htrans = cmd_q[i].trans; hwrite = cmd_q[i].write;
        haddr = cmd_q[i].addr; hsize = cmd_q[i].size;
      end else begin
        hsel = 1'b0; htrans = 2'b00;
      end
      hwdata = have_dp ? dp.wdata : 32'h0;
      @(negedge hclk);
      rdy = hready_bus;
      if (have_dp) begin
        if (!rdy) begin
          ob.waits = ob.waits + 4'd1;
          ob.wresp = ob.wresp | hresp_bus;
        end else begin
          ob.rdata = hrdata_bus;
          ob.resp  = hresp_bus;
          obs_q.push_back(ob);
          have_dp = 0;
        end
      end
      if (rdy && i < cmd_q.size()) begin
        dp = cmd_q[i];
        i++;
        have_dp = 1;
        ob = '0;
      end
      @(posedge hclk); #1;
    end
    checks++;
    if (guard >= 200) begin
      errors++;
      $display("FAIL bus_timeout: issued=%0d of %0d, required completion within 200 cycles", i, cmd_q.size());
    end
    hsel = 1'b0; htrans = 2'b00; hwdata = '0;
    cmd_q.delete();
  endtask

  task automatic test_reset();
    obs_t e, o;
    hrest_n = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    checks++;
    if ({hready_bus, hresp_bus, hrdata_bus} !== {1'b1, 2'b00, 32'h0}) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b resp=%b rdata=%h, expected 1/00/0", hready_bus, hresp_bus, hrdata_bus);
    end
    hrest_n = 1'b1;
    @(posedge hclk); #1;
    sel3 = 1'b1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h4; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h1234_5678;
    checks++;
    if (hready_bus !== 1'b0) begin
      errors++;
      $display("FAIL wait_entry: got ready=%b, expected 0", hready_bus);
    end
    @(posedge hclk); #2;
    hrest_n = 1'b0;
    #1;
    checks++;
    if ({hready_bus, hresp_bus, hrdata_bus} !== {1'b1, 2'b00, 32'h0}) begin
      errors++;
      $display("FAIL reset_mid_wait: got ready=%b resp=%b rdata=%h, expected 1/00/0", hready_bus, hresp_bus, hrdata_bus);
    end
    @(posedge hclk); #1;
    hrest_n = 1'b1;
    hwdata = '0;
    add(1, 2'b10, 0, 32'h4, 3'd2, 0, okay(32'h0, 4'd3));
    run_cmds();
    sel3 = 1'b0;
    add(1, 2'b10, 0, 32'h0, 3'd2, 0, okay(32'h0, 4'd0));
    run_cmds();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL reset_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int unsigned k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_xfer#%0d: got rdata=%h resp=%b waits=%0d wresp=%b, expected rdata=%h resp=%b waits=%0d wresp=%b",
                 k, o.rdata, o.resp, o.waits, o.wresp, e.rdata, e.resp, e.waits, e.wresp);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_wait0();
    obs_t e, o;
    sel3 = 1'b0;
    add(1, 2'b10, 1, 32'h10, 3'd2, 32'hDEAD_BEEF, okay(32'h0, 4'd0));
    add(1, 2'b10, 0, 32'h10, 3'd2, 0, okay(32'hDEAD_BEEF, 4'd0));
    run_cmds();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wait0_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int unsigned k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wait0_xfer#%0d: got rdata=%h resp=%b waits=%0d wresp=%b, expected rdata=%h resp=%b waits=%0d wresp=%b",
                 k, o.rdata, o.resp, o.waits, o.wresp, e.rdata, e.resp, e.waits, e.wresp);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_wait3();
    obs_t e, o;
    sel3 = 1'b1;
    add(1, 2'b10, 1, 32'h04, 3'd2, 32'hA5A5_0F0F, okay(32'h0, 4'd3));
    add(1, 2'b10, 0, 32'h04, 3'd2, 0, okay(32'hA5A5_0F0F, 4'd3));
    add(1, 2'b10, 0, 32'h3C, 3'd2, 0, okay(32'h0, 4'd3));
    add(1, 2'b10, 0, 32'h40, 3'd2, 0, err_rsp());
    add(1, 2'b10, 0, 32'h08, 3'd2, 0, okay(32'h0, 4'd3));
    run_cmds();
    sel3 = 1'b0;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wait3_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int unsigned k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wait3_xfer#%0d: got rdata=%h resp=%b waits=%0d wresp=%b, expected rdata=%h resp=%b waits=%0d wresp=%b",
                 k, o.rdata, o.resp, o.waits, o.wresp, e.rdata, e.resp, e.waits, e.wresp);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_byte_half();
    obs_t e, o;
    sel3 = 1'b0;
    add(1, 2'b10, 1, 32'h20, 3'd2, 32'h0, okay(32'h0, 4'd0));
    add(1, 2'b10, 1, 32'h22, 3'd0, 32'h77A5_6655, okay(32'h0, 4'd0));
    add(1, 2'b10, 1, 32'h20, 3'd1, 32'h9999_1234, okay(32'h0, 4'd0));
    add(1, 2'b10, 0, 32'h20, 3'd2, 0, okay(32'h00A5_1234, 4'd0));
    add(1, 2'b10, 1, 32'h24, 3'd2, 32'h0, okay(32'h0, 4'd0));
    add(1, 2'b10, 1, 32'h26, 3'd1, 32'hBEEF_1111, okay(32'h0, 4'd0));
    add(1, 2'b10, 1, 32'h25, 3'd0, 32'h2222_3C44, okay(32'h0, 4'd0));
    add(1, 2'b10, 0, 32'h24, 3'd2, 0, okay(32'hBEEF_3C00, 4'd0));
    run_cmds();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL lanes_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int unsigned k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL lanes_xfer#%0d: got rdata=%h resp=%b waits=%0d wresp=%b, expected rdata=%h resp=%b waits=%0d wresp=%b",
                 k, o.rdata, o.resp, o.waits, o.wresp, e.rdata, e.resp, e.waits, e.wresp);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_errors();
    obs_t e, o;
    sel3 = 1'b0;
    add(1, 2'b10, 1, 32'h30, 3'd2, 32'h1111_2222, okay(32'h0, 4'd0));
    add(1, 2'b10, 0, 32'h400, 3'd2, 0, err_rsp());
    add(1, 2'b10, 1, 32'h32, 3'd2, 32'hFFFF_FFFF, err_rsp());
    add(1, 2'b10, 1, 32'h30, 3'd3, 32'hFFFF_FFFF, err_rsp());
    add(1, 2'b10, 1, 32'h31, 3'd1, 32'hFFFF_FFFF, err_rsp());
    add(1, 2'b10, 0, 32'h3FC, 3'd2, 0, okay(32'h0, 4'd0));
    add(1, 2'b10, 0, 32'h30, 3'd2, 0, okay(32'h1111_2222, 4'd0));
    run_cmds();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL err_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int unsigned k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL err_xfer#%0d: got rdata=%h resp=%b waits=%0d wresp=%b, expected rdata=%h resp=%b waits=%0d wresp=%b",
                 k, o.rdata, o.resp, o.waits, o.wresp, e.rdata, e.resp, e.waits, e.wresp);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    logic [31:0] d [4];
    sel3 = 1'b0;
    for (int unsigned k = 0; k < 4; k++) d[k] = $urandom;
    add(1, 2'b10, 1, 32'h80, 3'd2, d[0], okay(32'h0, 4'd0));
    add(1, 2'b11, 1, 32'h84, 3'd2, d[1], okay(32'h0, 4'd0));
    add(1, 2'b01, 1, 32'h98, 3'd2, 32'hBAD0_0001, okay(32'h0, 4'd0));
    add(1, 2'b11, 1, 32'h88, 3'd2, d[2], okay(32'h0, 4'd0));
    add(0, 2'b10, 1, 32'h90, 3'd2, 32'hBAD0_0002, okay(32'h0, 4'd0));
    add(1, 2'b11, 1, 32'h8C, 3'd2, d[3], okay(32'h0, 4'd0));
    add(1, 2'b00, 1, 32'h94, 3'd2, 32'hBAD0_0003, okay(32'h0, 4'd0));
    add(1, 2'b10, 0, 32'h80, 3'd2, 0, okay(d[0], 4'd0));
    add(1, 2'b11, 0, 32'h84, 3'd2, 0, okay(d[1], 4'd0));
    add(1, 2'b11, 0, 32'h88, 3'd2, 0, okay(d[2], 4'd0));
    add(1, 2'b11, 0, 32'h8C, 3'd2, 0, okay(d[3], 4'd0));
    add(1, 2'b11, 0, 32'h90, 3'd2, 0, okay(32'h0, 4'd0));
    add(1, 2'b11, 0, 32'h94, 3'd2, 0, okay(32'h0, 4'd0));
    add(1, 2'b11, 0, 32'h98, 3'd2, 0, okay(32'h0, 4'd0));
    run_cmds();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL burst_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int unsigned k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL burst_xfer#%0d: got rdata=%h resp=%b waits=%0d wresp=%b, expected rdata=%h resp=%b waits=%0d wresp=%b",
                 k, o.rdata, o.resp, o.waits, o.wresp, e.rdata, e.resp, e.waits, e.wresp);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_wait0();
    test_wait3();
    test_byte_half();
    test_errors();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

endmodule
